// File: rtl/reflet_timer_pkg.sv
// reflet_timer_pkg: shared register map and CTRL bit layout for the Reflet
// timer peripheral.
//   timer_reg_e    register index (word offset from base_addr)
//   CTRL_*         bit positions inside the CTRL register
package reflet_timer_pkg;

  typedef enum logic [1:0] {
    TIMER_CTRL  = 2'd0,
    TIMER_PRESC = 2'd1,
    TIMER_COUNT = 2'd2,
    TIMER_CMP   = 2'd3
  } timer_reg_e;

  localparam int unsigned CTRL_RUN         = 0;
  localparam int unsigned CTRL_AUTO_RELOAD = 1;
  localparam int unsigned CTRL_IRQ_EN      = 2;
  localparam int unsigned CTRL_PENDING     = 3;

endpackage

// File: rtl/reflet_timer_prescaler.sv
// reflet_timer_prescaler: divides the clock by (presc+1) while running.
//   clk, reset   clock, synchronous active-low reset
//   enable       global enable; counter freezes when low
//   run          CTRL.RUN; counter only advances while set
//   clear        restart the prescale counter (CPU wrote PRESC or COUNT)
//   presc        divide value; 0 gives a tick every cycle
//   tick         1-cycle pulse, high in the cycle whose edge wraps the counter
module reflet_timer_prescaler #(
  parameter int unsigned wordsize = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                run,
  input  logic                clear,
  input  logic [wordsize-1:0] presc,
  output logic                tick
);

  logic [wordsize-1:0] cnt;
  logic                active;

  assign active = run & enable;

  // A CPU write at the same edge wins, so the tick is suppressed by clear.
  assign tick = active & ~clear & (cnt == presc);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (active) begin
      if (cnt == presc) cnt <= '0;
      else              cnt <= cnt + wordsize'(1);
    end
  end

endmodule

// File: rtl/reflet_timer.sv
// reflet_timer: memory-mapped timer on the Reflet bus.
//   clk, reset   clock, synchronous active-low reset
//   enable       global enable; freezes counting, writes and data_out
//   addr         byte address; registers at base_addr + i*(wordsize/8)
//   data_in      CPU write data
//   write_en     CPU write strobe
//   data_out     registered read data, zero when not selected or writing
//   int_out      PENDING & IRQ_EN
//   pwm_out      RUN & (COUNT < CMP), registered; only with REFLET_TIMER_PWM_EN
// Optional build macro: REFLET_TIMER_PWM_EN.
module reflet_timer
  import reflet_timer_pkg::*;
#(
  parameter int unsigned          wordsize  = 16,
  parameter logic [wordsize-1:0]  base_addr = wordsize'(16'hFF00)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [wordsize-1:0] addr,
  input  logic [wordsize-1:0] data_in,
  input  logic                write_en,
  output logic [wordsize-1:0] data_out,
  output logic                int_out
`ifdef REFLET_TIMER_PWM_EN
  ,
  output logic                pwm_out
`endif
);

  localparam int unsigned ALIGN = $clog2(wordsize / 8);

  logic                run, auto_reload, irq_en, pending;
  logic [wordsize-1:0] presc, count, cmp;

  logic [wordsize-1:0] offset;
  logic                sel;
  timer_reg_e          reg_idx;
  logic [wordsize-1:0] rdata;

  logic wr, wr_ctrl, wr_presc, wr_count, wr_cmp;
  logic tick, match;

  // Subtracting the base turns the decode into bit tests: upper bits zero
  // (in range, no wrap-around) and low bits zero (aligned).
  assign offset  = addr - base_addr;
  assign sel     = (offset[wordsize-1:ALIGN+2] == '0) && (offset[ALIGN-1:0] == '0);
  assign reg_idx = timer_reg_e'(offset[ALIGN+1:ALIGN]);

  assign wr       = sel & write_en & enable;
  assign wr_ctrl  = wr & (reg_idx == TIMER_CTRL);
  assign wr_presc = wr & (reg_idx == TIMER_PRESC);
  assign wr_count = wr & (reg_idx == TIMER_COUNT);
  assign wr_cmp   = wr & (reg_idx == TIMER_CMP);

  always_comb begin
    rdata = '0;
    case (reg_idx)
      TIMER_CTRL: begin
        rdata[CTRL_RUN]         = run;
        rdata[CTRL_AUTO_RELOAD] = auto_reload;
        rdata[CTRL_IRQ_EN]      = irq_en;
        rdata[CTRL_PENDING]     = pending;
      end
      TIMER_PRESC: rdata = presc;
      TIMER_COUNT: rdata = count;
      TIMER_CMP:   rdata = cmp;
      default:     rdata = '0;
    endcase
  end

  reflet_timer_prescaler #(
    .wordsize(wordsize)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .run    (run),
    .clear  (wr_presc | wr_count),
    .presc  (presc),
    .tick   (tick)
  );

  assign match = tick & (count == cmp);

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_out <= '0;
    end else if (enable) begin
      data_out <= (sel && !write_en) ? rdata : '0;
    end
  end

  // Priority ordering encodes the race rules: CPU writes to COUNT and RUN
  // beat the tick, while a match setting PENDING beats the W1C clear.
  always_ff @(posedge clk) begin
    if (!reset) begin
      run         <= 1'b0;
      auto_reload <= 1'b0;
      irq_en      <= 1'b0;
      pending     <= 1'b0;
      presc       <= '0;
      count       <= '0;
      cmp         <= '0;
    end else begin
      if (wr_ctrl) begin
        run         <= data_in[CTRL_RUN];
        auto_reload <= data_in[CTRL_AUTO_RELOAD];
        irq_en      <= data_in[CTRL_IRQ_EN];
      end else if (match && !auto_reload) begin
        run <= 1'b0;
      end

      if (match)                                pending <= 1'b1;
      else if (wr_ctrl && data_in[CTRL_PENDING]) pending <= 1'b0;

      if (wr_presc) presc <= data_in;
      if (wr_cmp)   cmp   <= data_in;

      if (wr_count) begin
        count <= data_in;
      end else if (tick) begin
        if (match) begin
          if (auto_reload) count <= '0;
        end else begin
          count <= count + wordsize'(1);
        end
      end
    end
  end

  assign int_out = pending & irq_en;

`ifdef REFLET_TIMER_PWM_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      pwm_out <= 1'b0;
    end else if (enable) begin
      pwm_out <= run & (count < cmp);
    end
  end
`endif

endmodule
